// File: rtl/de2_115_sopc_pio_pkg.sv
// Shared PIO definitions: register word addresses and edge-type codes.
// Used by the key PIO, the LED PIO and the software header generator.
package de2_115_sopc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Pin synchroniser plus per-bit edge detector.
// Ports: clk, reset (sync, high), in_port (async pins) -> level_o (synced), edge_o.
module pio_sync_edge
  import de2_115_sopc_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_FALL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise    = level_o & ~prev_q;
  assign fall    = ~level_o & prev_q;

  always_comb begin
    edge_o = '0;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_o = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_o = fall;
    end else begin
      edge_o = rise | fall;
    end
  end

endmodule

// File: rtl/de2_115_sopc_pio_key.sv
// Avalon-MM input PIO: synced pins, sticky W1C edge capture, maskable level irq.
// Ports: clk, reset, s1 slave (address/chipselect/read_n/write_n/writedata/readdata), in_port, irq.
module de2_115_sopc_pio_key
  import de2_115_sopc_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_FALL,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] edge_det;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] clr;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .level_o (level),
    .edge_o  (edge_det)
  );

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  assign clr = (wr_en && address == ADDR_EDGECAP)
             ? writedata[WIDTH-1:0] : '0;

  // Set has priority over clear so a new edge is never lost.
  assign cap_d = edge_det | (cap_q & ~clr);

  always_comb begin
    mask_d = mask_q;
    if (wr_en && address == ADDR_IRQMASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  // Mux sees pre-write register values, so read+write returns old data.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        ADDR_DATA:    rdata_d = 32'(level);
        ADDR_IRQMASK: rdata_d = 32'(mask_q);
        ADDR_EDGECAP: rdata_d = 32'(cap_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_de2_115_sopc_pio_key.sv
// Bench for de2_115_sopc_pio_key: cycle model compare plus directed checks.
// Inputs change on negedge; outputs sampled on negedge.
module tb_de2_115_sopc_pio_key;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int ET = 1;

  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  address = 0;
  logic        chipselect = 0;
  logic        read_n = 1;
  logic        write_n = 1;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = 0;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  de2_115_sopc_pio_key #(
    .WIDTH(W), .EDGE_TYPE(ET), .SYNC_STAGES(N)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  // Model: pin history; synced value is the pin sampled N-1 edges ago.
  logic [W-1:0] hist [0:N];
  logic [W-1:0] m_mask, m_cap;
  logic [31:0]  m_rd;

  always @(posedge clk) begin
    logic [W-1:0] lv, pv, ed, cl;
    if (reset) begin
      for (int i = 0; i <= N; i++) hist[i] = '0;
      m_mask = '0;
      m_cap  = '0;
      m_rd   = '0;
    end else begin
      lv = hist[N-1];
      pv = hist[N];
      if (ET == 0) ed = lv & ~pv;
      else if (ET == 1) ed = ~lv & pv;
      else ed = lv ^ pv;
      cl = (chipselect && !write_n && address == 3)
         ? writedata[W-1:0] : '0;
      if (chipselect && !read_n) begin
        if (address == 0) m_rd = {28'd0, lv};
        else if (address == 2) m_rd = {28'd0, m_mask};
        else if (address == 3) m_rd = {28'd0, m_cap};
        else m_rd = 0;
      end
      m_cap = ed | (m_cap & ~cl);
      if (chipselect && !write_n && address == 2)
        m_mask = writedata[W-1:0];
      for (int i = N; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_port;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_readdata", readdata, m_rd);
      chk("cyc_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string nm);
    chipselect = 1; read_n = 0; address = a;
    @(negedge clk);
    chipselect = 0; read_n = 1;
    chk(nm, readdata, exp);
  endtask

  initial begin
    // 1 reset
    reset = 1; in_port = 4'hF;
    tick(1);
    chk_en = 1;
    tick(1);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    reset = 0;
    tick(3);
    rd(2, 32'h0, "rst_mask");
    rd(3, 32'h0, "rst_cap");

    // 2 falling edge on bit0, exact latency
    in_port = 4'hE;
    wr(2, 32'h1);
    tick(1);
    chk("fall_irq_early", {31'd0, irq}, 32'h0);
    tick(1);
    chk("fall_irq", {31'd0, irq}, 32'h1);
    rd(3, 32'h1, "fall_cap");
    rd(0, 32'hE, "fall_data");

    // 3 write-one-to-clear
    in_port = 4'hA;
    tick(3);
    rd(3, 32'h5, "w1c_cap5");
    wr(3, 32'h4);
    rd(3, 32'h1, "w1c_cap1");
    wr(3, 32'h1);
    rd(3, 32'h0, "w1c_cap0");
    chk("w1c_irq", {31'd0, irq}, 32'h0);

    // 4 set and clear in the same cycle
    in_port = 4'hB; tick(3);
    in_port = 4'hA; tick(3);
    chk("sc_irq_pre", {31'd0, irq}, 32'h1);
    in_port = 4'hB; tick(3);
    in_port = 4'hA; tick(2);
    wr(3, 32'h1);
    chk("sc_irq", {31'd0, irq}, 32'h1);
    rd(3, 32'h1, "sc_cap");

    // 5 masking
    wr(3, 32'h1);
    in_port = 4'h8; tick(3);
    rd(3, 32'h2, "mask_cap2");
    chk("mask_irq0", {31'd0, irq}, 32'h0);
    wr(2, 32'h3);
    chk("mask_irq1", {31'd0, irq}, 32'h1);
    wr(2, 32'h0);
    chk("mask_irq_off", {31'd0, irq}, 32'h0);
    rd(3, 32'h2, "mask_cap_kept");

    // 6 reset during a read
    in_port = 4'hF; tick(3);
    in_port = 4'h0; tick(3);
    wr(2, 32'hF);
    rd(3, 32'hF, "r6_cap");
    chk("r6_irq_pre", {31'd0, irq}, 32'h1);
    reset = 1; chipselect = 1; read_n = 0; address = 3;
    in_port = 4'h6;
    @(negedge clk);
    reset = 0; chipselect = 0; read_n = 1;
    chk("r6_readdata", readdata, 32'h0);
    chk("r6_irq", {31'd0, irq}, 32'h0);
    tick(3);
    rd(0, 32'h6, "r6_data");
    rd(2, 32'h0, "r6_mask");
    rd(3, 32'h0, "r6_cap0");
    rd(1, 32'h0, "rsvd");

    tick(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
